// File: rtl/sap_control_sequencer.sv
// SAP-style microcoded control sequencer: T-state counter plus opcode/flag decode into a 16-bit control word.
// Optional macro SEQ_EARLY_RESET_EN: wrap to T0 right after each opcode's last active execute step.
module sap_control_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int STEP_W    = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [3:0]        opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [15:0]       ctrl,
  output logic [STEP_W-1:0] step,
  output logic              halted
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [STEP_W-1:0] T0        = STEP_W'(0);
  localparam logic [STEP_W-1:0] T1        = STEP_W'(1);
  localparam logic [STEP_W-1:0] T2        = STEP_W'(2);
  localparam logic [STEP_W-1:0] T3        = STEP_W'(3);
  localparam logic [STEP_W-1:0] T4        = STEP_W'(4);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t              state_r, state_nxt_s;
  logic [STEP_W-1:0]   step_r, step_nxt_s;
  logic [STEP_W-1:0]   wrap_step_s;
  logic [15:0]         exec_s;
  logic [15:0]         ctrl_s;

`ifdef SEQ_EARLY_RESET_EN
  // Last execute step that can assert anything; not-taken jumps still end at T2.
  function automatic logic [STEP_W-1:0] last_step_of(input logic [3:0] op);
    logic [STEP_W-1:0] last;
    case (op)
      4'h1, 4'h4:                      last = T3;
      4'h2, 4'h3:                      last = T4;
      4'h5, 4'h6, 4'h7, 4'h8, 4'hE,
      4'hF:                            last = T2;
      default:                         last = T1;
    endcase
    return last;
  endfunction
`endif

  // Execute-phase microcode for T2..T4; any other step decodes to nothing.
  always_comb begin
    exec_s = 16'h0000;
    case (opcode)
      4'h1: begin
        if (step_r == T2)      exec_s = C_IO | C_MI;
        else if (step_r == T3) exec_s = C_RO | C_AI;
        else                   exec_s = 16'h0000;
      end
      4'h2, 4'h3: begin
        if (step_r == T2)      exec_s = C_IO | C_MI;
        else if (step_r == T3) exec_s = C_RO | C_BI;
        else if (step_r == T4) exec_s = C_EO | C_AI | C_FI | ((opcode == 4'h3) ? C_SU : 16'h0000);
        else                   exec_s = 16'h0000;
      end
      4'h4: begin
        if (step_r == T2)      exec_s = C_IO | C_MI;
        else if (step_r == T3) exec_s = C_AO | C_RI;
        else                   exec_s = 16'h0000;
      end
      4'h5: exec_s = (step_r == T2) ? (C_IO | C_AI) : 16'h0000;
      4'h6: exec_s = (step_r == T2) ? (C_IO | C_J) : 16'h0000;
      4'h7: exec_s = ((step_r == T2) && flag_c) ? (C_IO | C_J) : 16'h0000;
      4'h8: exec_s = ((step_r == T2) && flag_z) ? (C_IO | C_J) : 16'h0000;
      4'hE: exec_s = (step_r == T2) ? (C_AO | C_OI) : 16'h0000;
      4'hF: exec_s = (step_r == T2) ? C_HLT : 16'h0000;
      default: exec_s = 16'h0000;
    endcase
  end

  // Full control word: halt override, shared fetch, then execute microcode.
  always_comb begin
    ctrl_s = 16'h0000;
    if (state_r == ST_HALT) begin
      ctrl_s = C_HLT;
    end else begin
      case (step_r)
        T0:      ctrl_s = C_CO | C_MI;
        T1:      ctrl_s = C_RO | C_II | C_CE;
        default: ctrl_s = exec_s;
      endcase
    end
  end

  // Next-state: halt on an enabled HLT step, otherwise advance and wrap.
  always_comb begin
    state_nxt_s = state_r;
    step_nxt_s  = step_r;
`ifdef SEQ_EARLY_RESET_EN
    wrap_step_s = last_step_of(opcode);
`else
    wrap_step_s = LAST_STEP;
`endif
    if ((state_r == ST_RUN) && clk_en) begin
      if (ctrl_s[15]) begin
        state_nxt_s = ST_HALT;
      end else if ((step_r == wrap_step_s) || (step_r == LAST_STEP)) begin
        step_nxt_s = T0;
      end else begin
        step_nxt_s = step_r + STEP_W'(1);
      end
    end else begin
      state_nxt_s = state_r;
      step_nxt_s  = step_r;
    end
  end

  // State registers; reset wins over clk_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
      step_r  <= T0;
    end else begin
      state_r <= state_nxt_s;
      step_r  <= step_nxt_s;
    end
  end

  assign ctrl   = ctrl_s;
  assign step   = step_r;
  assign halted = (state_r == ST_HALT);

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Self-checking bench for sap_control_sequencer: directed steps plus random traffic against a microcode-table model.
module tb_sap_control_sequencer;
  localparam int NS = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic [3:0]    opcode;
  logic          flag_c;
  logic          flag_z;
  logic [15:0]   ctrl;
  logic [SW-1:0] step;
  logic          halted;

  int checks   = 0;
  int failures = 0;

  // Model: instruction = fetch words, then a per-opcode list of execute words.
  int          m_step;
  bit          m_halted;
  logic [15:0] ucode [16][3];
  int          ulen  [16];

  sap_control_sequencer #(.NUM_STEPS(NS), .STEP_W(SW)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .opcode (opcode),
    .flag_c (flag_c),
    .flag_z (flag_z),
    .ctrl   (ctrl),
    .step   (step),
    .halted (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_ctrl();
    logic [15:0] w;
    int idx;
    if (m_halted)    return 16'h8000;
    if (m_step == 0) return 16'h4004;
    if (m_step == 1) return 16'h1408;
    idx = m_step - 2;
    if (idx >= ulen[opcode]) return 16'h0000;
    w = ucode[opcode][idx];
    if (opcode == 4'h7 && !flag_c) w = 16'h0000;
    if (opcode == 4'h8 && !flag_z) w = 16'h0000;
    return w;
  endfunction

  function automatic int model_last();
`ifdef SEQ_EARLY_RESET_EN
    return 1 + ulen[opcode];
`else
    return NS - 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational ctrl, clock, advance model, check state.
  task automatic cyc(input logic [3:0] op, input logic fc, input logic fz, input logic en, input logic r);
    logic [15:0] w;
    opcode = op; flag_c = fc; flag_z = fz; clk_en = en; rst = r;
    #1;
    check("ctrl", ctrl, model_ctrl());
    w = model_ctrl();
    @(posedge clk);
    if (r) begin
      m_step = 0; m_halted = 1'b0;
    end else if (en && !m_halted) begin
      if (w[15])                       m_halted = 1'b1;
      else if (m_step == model_last()) m_step = 0;
      else                             m_step = m_step + 1;
    end
    #1;
    check("step", 16'(step), 16'(m_step));
    check("halted", 16'(halted), 16'(m_halted));
  endtask

  initial begin
    int n;
    int exp_n;
    for (int i = 0; i < 16; i++) begin
      ulen[i] = 0;
      for (int j = 0; j < 3; j++) ucode[i][j] = 16'h0000;
    end
    ulen[1]  = 2; ucode[1][0]  = 16'h4800; ucode[1][1] = 16'h1200;
    ulen[2]  = 3; ucode[2][0]  = 16'h4800; ucode[2][1] = 16'h1020; ucode[2][2] = 16'h0281;
    ulen[3]  = 3; ucode[3][0]  = 16'h4800; ucode[3][1] = 16'h1020; ucode[3][2] = 16'h02C1;
    ulen[4]  = 2; ucode[4][0]  = 16'h4800; ucode[4][1] = 16'h2100;
    ulen[5]  = 1; ucode[5][0]  = 16'h0A00;
    ulen[6]  = 1; ucode[6][0]  = 16'h0802;
    ulen[7]  = 1; ucode[7][0]  = 16'h0802;
    ulen[8]  = 1; ucode[8][0]  = 16'h0802;
    ulen[14] = 1; ucode[14][0] = 16'h0110;
    ulen[15] = 1; ucode[15][0] = 16'h8000;

    rst = 1'b1; clk_en = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_step = 0; m_halted = 1'b0;

    // Idle with clk_en low
    for (int i = 0; i < 10; i++) cyc(4'h2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("idle_ctrl", ctrl, 16'h4004);

    // ADD full instruction
    for (int i = 0; i < 5; i++) cyc(4'h2, 1'b0, 1'b0, 1'b1, 1'b0);
    check("add_wrap_step", 16'(step), 16'h0000);

    // SUB, JC taken, JC not taken, JZ both ways
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(4'h7, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(4'h7, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(4'h8, 1'b0, 1'b1, 1'b1, 1'b0);

    // HLT: enter halt, hold across 20 pulses with changing inputs, then reset
    cyc(4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hlt_entered", 16'(halted), 16'h0001);
    for (int i = 0; i < 20; i++) begin
      cyc(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      check("hlt_ctrl", ctrl, 16'h8000);
    end
    cyc(4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    check("hlt_reset_step", 16'(step), 16'h0000);

    // Reset at LDA T3 together with clk_en
    for (int i = 0; i < 3; i++) cyc(4'h1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("lda_at_t3", 16'(step), 16'h0003);
    cyc(4'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("lda_reset_wins", 16'(step), 16'h0000);

    // Instruction length in clk_en pulses
`ifdef SEQ_EARLY_RESET_EN
    exp_n = 3;
`else
    exp_n = 5;
`endif
    n = 0;
    do begin cyc(4'h5, 1'b0, 1'b0, 1'b1, 1'b0); n++; end while (step != 3'd0 && n < 10);
    check("ldi_pulses", 16'(n), 16'(exp_n));
`ifdef SEQ_EARLY_RESET_EN
    exp_n = 2;
`else
    exp_n = 5;
`endif
    n = 0;
    do begin cyc(4'h0, 1'b0, 1'b0, 1'b1, 1'b0); n++; end while (step != 3'd0 && n < 10);
    check("nop_pulses", 16'(n), 16'(exp_n));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
